cypher_stream_ctrl: RTL and testbench
=====================================

Name: cypher_stream_ctrl

Overview:
- Frame-level sequencer for the 8-bit LFSR keystream cipher datapath.
- Accepts a start command with a byte count, then seeds and warms up the keystream generator.
- Streams that many bytes through an XOR with (LFSR state ^ KEY) over valid/ready handshakes, and signals completion.
- Sits between the byte source (UART/host FIFO) and the byte sink; owns when the LFSR steps, so the keystream stays in lockstep with accepted data.

Parameters:
- KEY, 8'h9D, constant XORed with the LFSR state to form the keystream byte.
- WARMUP, 8, LFSR steps taken after start before the first data byte (0 allowed).
- LEN_W, 8, width of the frame length and remaining-byte counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle frame start command; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- mode  input  1  1 = cipher (XOR keystream), 0 = bypass (data passes unchanged, LFSR still steps).
- frame_len  input  LEN_W  number of bytes in the frame, latched on start.
- in_data  input  8  input byte.
- in_valid  input  1  input byte valid.
- in_ready  output  1  controller can accept the input byte.
- out_data  output  8  output byte (registered).
- out_valid  output  1  output byte valid.
- out_ready  input  1  sink accepts the output byte.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at normal frame completion.

Behaviour:
- Reset (reset=0, async): state=IDLE, LFSR=8'h00, all counters 0, out_data=0, out_valid=0, in_ready=0, busy=0, done=0.
- LFSR step: q <= {q[6:0], ~(q[0]^q[7])}. Keystream byte ks = q ^ KEY. From 0x00 the sequence is 00,01,02,05,0A,15,2A,55,AA.
- IDLE:
  - start=1 with frame_len!=0: latch mode and frame_len into rem, sync-clear the LFSR to 0, load the warm counter with WARMUP, go to WARM (to RUN directly if WARMUP==0).
  - start=1 with frame_len==0: stay in IDLE, pulse done next cycle.
- WARM: step the LFSR every cycle, decrement the warm counter; go to RUN after the WARMUP-th step. in_ready=0.
- RUN:
  - in_ready = !out_valid || out_ready (single output register, full throughput).
  - On accept (in_valid && in_ready): out_data <= mode ? in_data^ks : in_data; out_valid<=1; LFSR steps; rem decrements. Latency is 1 cycle from accept to out_valid.
  - Accept of the last byte (rem==1) goes to FLUSH.
  - If out_valid && out_ready with no new accept, out_valid<=0.
- FLUSH:
  - in_ready=0.
  - When out_valid==0, or out_valid && out_ready: clear out_valid, go to IDLE, pulse done for 1 cycle.
- out_data/out_valid hold stable while out_valid && !out_ready (no drop, no overwrite).
- Simultaneous out_ready and accept in the same cycle: the register is reloaded and out_valid stays 1.
- start while busy is ignored.
- abort (any state): state=IDLE next cycle, out_valid=0, no done, LFSR holds its value (re-seeded by the next start).
- abort and start in the same cycle: abort wins; start is ignored.
- rem never wraps. Frame length range is 1..2^LEN_W-1.
- busy is a registered state decode; done is a registered pulse.

Decomposition:
- Shared package cypher_pkg: LFSR width (8), KEY default, state enum {IDLE, WARM, RUN, FLUSH}, the LFSR next-state function.
- One natural sub-module, cypher_lfsr: 8-bit xnor-feedback LFSR with step enable, sync clear and async active-low reset, output q.
- The controller FSM, counters and output register stay in cypher_stream_ctrl.

Test Plan:
- WARMUP=0, mode=1, start with frame_len=2, in bytes 00,00, out_ready=1 -> out 9D then 9C; done pulses once after the second byte transfers; busy then falls.
- WARMUP=8, mode=1, frame_len=1, in 00 -> in_ready stays low for 8 cycles after start; out 37 (AA^9D); done pulses once.
- mode=0, frame_len=3, in 11,22,33 -> out 11,22,33 unchanged. A following cipher frame with WARMUP=0 and in 00 -> out 9D (LFSR re-cleared on start).
- Backpressure: frame_len=4, out_ready held low 5 cycles mid-frame -> out_data stable, in_ready=0, no byte lost or duplicated; the order and keystream still match 9D,9C,9F,98 XOR the inputs.
- abort during RUN after 1 of 3 bytes -> IDLE next cycle, out_valid=0, no done. start during busy is ignored; start with frame_len=0 gives a done pulse without busy.
- Async reset asserted mid-RUN -> all outputs are 0 immediately; after release a new frame reproduces the 9D-first sequence.

Source files
------------

// File: rtl/cypher_pkg.sv
// rtl/cypher_pkg.sv - shared types, constants and LFSR step function for the keystream cipher
package cypher_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] KEY_DEFAULT = 8'h9D;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WARM  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_e;

   // xnor feedback keeps the all-zero seed out of the lock-up state
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], ~(q[0] ^ q[LFSR_W-1])};
   endfunction

endpackage

// File: rtl/cypher_lfsr.sv
// rtl/cypher_lfsr.sv - 8-bit xnor-feedback LFSR with step enable and sync clear
module cypher_lfsr
   import cypher_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              step_i,
   output logic [LFSR_W-1:0] q_o
);

   logic [LFSR_W-1:0] q_q;
   logic [LFSR_W-1:0] q_d;

   // clear has priority so a new frame always starts from the zero seed
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (step_i) begin
         q_d = lfsr_next(q_q);
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/cypher_stream_ctrl.sv
// rtl/cypher_stream_ctrl.sv - frame sequencer streaming bytes through the LFSR keystream XOR
module cypher_stream_ctrl
   import cypher_pkg::*;
#(
   parameter logic [7:0] KEY    = KEY_DEFAULT,
   parameter int         WARMUP = 8,
   parameter int         LEN_W  = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic [LEN_W-1:0] frame_len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam logic [7:0] WARM_INIT   = 8'(WARMUP);
   localparam state_e     AFTER_START = (WARMUP == 0) ? RUN : WARM;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [7:0]       warm_q, warm_d;
   logic             mode_q, mode_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             lfsr_clr;
   logic             lfsr_step;
   logic [7:0]       lfsr_q;
   logic [7:0]       ks;
   logic             in_ready_c;
   logic             accept;

   cypher_lfsr u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (lfsr_clr),
      .step_i (lfsr_step),
      .q_o    (lfsr_q)
   );

   assign ks = lfsr_q ^ KEY;

   // single output register: a new byte may enter whenever the current one leaves
   always_comb begin
      in_ready_c = (state_q == RUN) && (!out_valid_q || out_ready);
   end

   assign accept = in_valid && in_ready_c;

   // next-state, counters, output register and LFSR control
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      warm_d      = warm_q;
      mode_d      = mode_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      lfsr_clr    = 1'b0;
      lfsr_step   = 1'b0;

      if (abort) begin
         // LFSR is left alone; the next start re-seeds it anyway
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (frame_len == '0) begin
                     done_d = 1'b1;
                  end else begin
                     mode_d   = mode;
                     rem_d    = frame_len;
                     warm_d   = WARM_INIT;
                     lfsr_clr = 1'b1;
                     state_d  = AFTER_START;
                  end
               end
            end

            WARM: begin
               lfsr_step = 1'b1;
               warm_d    = warm_q - 8'd1;
               if (warm_q == 8'd1) begin
                  state_d = RUN;
               end
            end

            RUN: begin
               if (accept) begin
                  out_data_d  = mode_q ? (in_data ^ ks) : in_data;
                  out_valid_d = 1'b1;
                  lfsr_step   = 1'b1;
                  rem_d       = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_d = FLUSH;
                  end
               end else if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
               end
            end

            FLUSH: begin
               if (!out_valid_q || out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
                  done_d      = 1'b1;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // registered state, counters and outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         warm_q      <= '0;
         mode_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         warm_q      <= warm_d;
         mode_q      <= mode_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_cypher_stream_ctrl.sv
// tb/tb_cypher_stream_ctrl.sv - self-checking bench for cypher_stream_ctrl (WARMUP 0 and 8 instances)
module tb_cypher_stream_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start_s     [2];
   logic       abort_s     [2];
   logic       mode_s      [2];
   logic [7:0] frame_len_s [2];
   logic [7:0] in_data_s   [2];
   logic       in_valid_s  [2];
   logic       out_ready_s [2];
   logic       in_ready_w  [2];
   logic [7:0] out_data_w  [2];
   logic       out_valid_w [2];
   logic       busy_w      [2];
   logic       done_w      [2];

   int checks = 0;
   int errors = 0;

   // behavioural model state, one set per instance
   logic       m_act   [2];
   int         m_warm  [2];
   int         m_toacc [2];
   int         m_totx  [2];
   int         m_idx   [2];
   logic       m_mode  [2];
   logic       m_done  [2];
   logic [7:0] exp_mem [2][64];
   int         wr      [2];
   int         rd      [2];
   logic       hold_q  [2];
   logic [7:0] hold_d  [2];
   logic [7:0] out_log [2][16];
   int         nlog    [2];
   int         ndone   [2];

   cypher_stream_ctrl #(.KEY(8'h9D), .WARMUP(0), .LEN_W(8)) u_dut0 (
      .clk(clk), .reset(rst_n), .start(start_s[0]), .abort(abort_s[0]), .mode(mode_s[0]),
      .frame_len(frame_len_s[0]), .in_data(in_data_s[0]), .in_valid(in_valid_s[0]),
      .in_ready(in_ready_w[0]), .out_data(out_data_w[0]), .out_valid(out_valid_w[0]),
      .out_ready(out_ready_s[0]), .busy(busy_w[0]), .done(done_w[0])
   );

   cypher_stream_ctrl #(.KEY(8'h9D), .WARMUP(8), .LEN_W(8)) u_dut8 (
      .clk(clk), .reset(rst_n), .start(start_s[1]), .abort(abort_s[1]), .mode(mode_s[1]),
      .frame_len(frame_len_s[1]), .in_data(in_data_s[1]), .in_valid(in_valid_s[1]),
      .in_ready(in_ready_w[1]), .out_data(out_data_w[1]), .out_valid(out_valid_w[1]),
      .out_ready(out_ready_s[1]), .busy(busy_w[1]), .done(done_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // keystream byte after n steps from the zero seed
   function automatic logic [7:0] ks_at(input int n);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < n; i++) s = {s[6:0], ~(s[0] ^ s[7])};
      return s ^ 8'h9D;
   endfunction

   // model compare and advance, once per cycle at the falling edge
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int pend;
         int wu;
         logic exp_ir;
         logic nd;
         logic acc;
         logic xfer;
         wu = (d == 0) ? 0 : 8;
         if (!rst_n) begin
            chk(out_valid_w[d] == 1'b0, "rst_out_valid", 32'(out_valid_w[d]), 0);
            chk(out_data_w[d] == 8'h00, "rst_out_data", 32'(out_data_w[d]), 0);
            chk(busy_w[d] == 1'b0, "rst_busy", 32'(busy_w[d]), 0);
            chk(done_w[d] == 1'b0, "rst_done", 32'(done_w[d]), 0);
            chk(in_ready_w[d] == 1'b0, "rst_in_ready", 32'(in_ready_w[d]), 0);
            m_act[d] = 0; m_warm[d] = 0; m_toacc[d] = 0; m_totx[d] = 0; m_idx[d] = 0;
            m_mode[d] = 0; m_done[d] = 0; wr[d] = 0; rd[d] = 0; hold_q[d] = 0;
         end else begin
            pend   = wr[d] - rd[d];
            exp_ir = m_act[d] && (m_warm[d] == 0) && (m_toacc[d] > 0) && (pend == 0 || out_ready_s[d]);
            chk(busy_w[d] == m_act[d], "busy", 32'(busy_w[d]), 32'(m_act[d]));
            chk(done_w[d] == m_done[d], "done", 32'(done_w[d]), 32'(m_done[d]));
            chk(out_valid_w[d] == (pend > 0), "out_valid", 32'(out_valid_w[d]), 32'(pend > 0));
            chk(in_ready_w[d] == exp_ir, "in_ready", 32'(in_ready_w[d]), 32'(exp_ir));
            if (done_w[d]) ndone[d]++;
            if (hold_q[d]) chk(out_data_w[d] == hold_d[d], "hold_data", 32'(out_data_w[d]), 32'(hold_d[d]));
            if (out_valid_w[d] && out_ready_s[d] && pend > 0)
               chk(out_data_w[d] == exp_mem[d][rd[d] % 64], "out_data",
                   32'(out_data_w[d]), 32'(exp_mem[d][rd[d] % 64]));
            hold_q[d] = out_valid_w[d] && !out_ready_s[d] && !abort_s[d];
            hold_d[d] = out_data_w[d];

            acc  = exp_ir && in_valid_s[d];
            xfer = (pend > 0) && out_ready_s[d];
            nd   = 1'b0;
            if (abort_s[d]) begin
               m_act[d] = 0; m_warm[d] = 0; m_toacc[d] = 0; m_totx[d] = 0; rd[d] = wr[d];
            end else if (!m_act[d]) begin
               if (start_s[d]) begin
                  if (frame_len_s[d] == 8'd0) begin
                     nd = 1'b1;
                  end else begin
                     m_act[d] = 1; m_warm[d] = wu; m_toacc[d] = frame_len_s[d];
                     m_totx[d] = frame_len_s[d]; m_idx[d] = 0; m_mode[d] = mode_s[d];
                  end
               end
            end else begin
               if (m_warm[d] > 0) m_warm[d]--;
               if (acc) begin
                  exp_mem[d][wr[d] % 64] = m_mode[d] ? (in_data_s[d] ^ ks_at(wu + m_idx[d])) : in_data_s[d];
                  wr[d]++; m_idx[d]++; m_toacc[d]--;
               end
               if (xfer) begin
                  out_log[d][nlog[d] % 16] = out_data_w[d];
                  nlog[d]++; rd[d]++; m_totx[d]--;
                  if (m_totx[d] == 0) begin
                     m_act[d] = 0;
                     nd = 1'b1;
                  end
               end
            end
            m_done[d] = nd;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int d, input int len, input logic md);
      start_s[d] = 1'b1; frame_len_s[d] = 8'(len); mode_s[d] = md;
      cyc(1);
      start_s[d] = 1'b0;
   endtask

   task automatic send(input int d, input logic [7:0] b);
      int t;
      t = 0;
      in_valid_s[d] = 1'b1; in_data_s[d] = b;
      @(negedge clk);
      while (!in_ready_w[d] && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk(t < 100, "send_timeout", 32'(t), 100);
      cyc(1);
      in_valid_s[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int t;
      t = 0;
      @(negedge clk);
      while (busy_w[d] && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(t < 200, "idle_timeout", 32'(t), 200);
      cyc(2);
   endtask

   task automatic chk_log(input int d, input int i, input logic [7:0] req);
      chk(out_log[d][i] == req, "log_byte", 32'(out_log[d][i]), 32'(req));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int nd0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 0; abort_s[d] = 0; mode_s[d] = 0; frame_len_s[d] = 0;
         in_data_s[d] = 0; in_valid_s[d] = 0; out_ready_s[d] = 1; nlog[d] = 0; ndone[d] = 0;
      end
      chk(ks_at(0) == 8'h9D, "model_ks0", 32'(ks_at(0)), 32'h9D);
      chk(ks_at(8) == 8'h37, "model_ks8", 32'(ks_at(8)), 32'h37);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(2);

      // two cipher bytes, no warm-up
      nlog[0] = 0; nd0 = ndone[0];
      start_frame(0, 2, 1'b1);
      send(0, 8'h00);
      send(0, 8'h00);
      wait_idle(0);
      chk(nlog[0] == 2, "t1_count", 32'(nlog[0]), 2);
      chk_log(0, 0, 8'h9D);
      chk_log(0, 1, 8'h9C);
      chk(ndone[0] == nd0 + 1, "t1_done", 32'(ndone[0] - nd0), 1);

      // eight warm-up steps before the first byte
      nlog[1] = 0;
      start_frame(1, 1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk(in_ready_w[1] == 1'b0, "t2_warm_ready", 32'(in_ready_w[1]), 0);
      end
      @(negedge clk);
      chk(in_ready_w[1] == 1'b1, "t2_run_ready", 32'(in_ready_w[1]), 1);
      @(posedge clk); #1;
      send(1, 8'h00);
      wait_idle(1);
      chk(nlog[1] == 1, "t2_count", 32'(nlog[1]), 1);
      chk_log(1, 0, 8'h37);
      chk(ndone[1] == 1, "t2_done", 32'(ndone[1]), 1);

      // bypass frame then a cipher frame re-seeded from zero
      nlog[0] = 0;
      start_frame(0, 3, 1'b0);
      send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
      wait_idle(0);
      start_frame(0, 1, 1'b1);
      send(0, 8'h00);
      wait_idle(0);
      chk(nlog[0] == 4, "t3_count", 32'(nlog[0]), 4);
      chk_log(0, 0, 8'h11); chk_log(0, 1, 8'h22); chk_log(0, 2, 8'h33); chk_log(0, 3, 8'h9D);

      // sink stalls for five cycles mid-frame
      nlog[0] = 0;
      start_frame(0, 4, 1'b1);
      fork
         begin
            send(0, 8'hA0); send(0, 8'hB1); send(0, 8'hC2); send(0, 8'hD3);
         end
         begin
            cyc(2); out_ready_s[0] = 1'b0; cyc(5); out_ready_s[0] = 1'b1;
         end
      join
      wait_idle(0);
      chk(nlog[0] == 4, "t4_count", 32'(nlog[0]), 4);
      chk_log(0, 0, 8'h3D); chk_log(0, 1, 8'h2D); chk_log(0, 2, 8'h5D); chk_log(0, 3, 8'h4B);

      // abort after the first of three bytes
      nd0 = ndone[0];
      start_frame(0, 3, 1'b1);
      send(0, 8'h00);
      abort_s[0] = 1'b1; cyc(1); abort_s[0] = 1'b0;
      @(negedge clk);
      chk(busy_w[0] == 1'b0, "t5_abort_busy", 32'(busy_w[0]), 0);
      chk(out_valid_w[0] == 1'b0, "t5_abort_valid", 32'(out_valid_w[0]), 0);
      cyc(2);
      chk(ndone[0] == nd0, "t5_abort_nodone", 32'(ndone[0] - nd0), 0);

      // start while busy is ignored
      nlog[0] = 0; nd0 = ndone[0];
      start_frame(0, 2, 1'b1);
      start_frame(0, 5, 1'b0);
      send(0, 8'h00); send(0, 8'h00);
      wait_idle(0);
      chk(nlog[0] == 2, "t6_count", 32'(nlog[0]), 2);
      chk_log(0, 1, 8'h9C);
      chk(ndone[0] == nd0 + 1, "t6_done", 32'(ndone[0] - nd0), 1);

      // abort beats start; zero-length start only pulses done
      nd0 = ndone[0];
      abort_s[0] = 1'b1; start_frame(0, 3, 1'b1); abort_s[0] = 1'b0;
      @(negedge clk);
      chk(busy_w[0] == 1'b0, "t7_abort_start", 32'(busy_w[0]), 0);
      @(posedge clk); #1;
      start_frame(0, 0, 1'b1);
      cyc(3);
      chk(ndone[0] == nd0 + 1, "t7_zero_done", 32'(ndone[0] - nd0), 1);

      // asynchronous reset in the middle of a frame
      start_frame(0, 3, 1'b1);
      out_ready_s[0] = 1'b0;
      send(0, 8'h55);
      #2 rst_n = 1'b0;
      #1;
      chk(out_valid_w[0] == 1'b0, "t8_rst_valid", 32'(out_valid_w[0]), 0);
      chk(out_data_w[0] == 8'h00, "t8_rst_data", 32'(out_data_w[0]), 0);
      chk(busy_w[0] == 1'b0, "t8_rst_busy", 32'(busy_w[0]), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready_s[0] = 1'b1;
      cyc(1);
      nlog[0] = 0;
      start_frame(0, 1, 1'b1);
      send(0, 8'h00);
      wait_idle(0);
      chk(nlog[0] == 1, "t8_count", 32'(nlog[0]), 1);
      chk_log(0, 0, 8'h9D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
